// File: rtl/pcileech_pcie_tlp_err_collector_if.sv
// Event inputs, dispatched error pulses and diagnostic counters of the TLP error collector.
interface pcileech_pcie_tlp_err_collector_if #(
  parameter int NSRC = 2
);
  logic [NSRC-1:0] ev_fatal;
  logic [NSRC-1:0] ev_cor;
  logic [NSRC-1:0] ev_ur;
  logic [NSRC-1:0] ev_ma;
  logic            clear;
  logic            tlp_err_fatal;
  logic            tlp_err_cor;
  logic            tlp_err_ur;
  logic            tlp_master_abort;
  logic            pending_any;
  logic [3:0]      ovf;
  logic [15:0]     total_fatal;
  logic [15:0]     total_cor;
  logic [15:0]     total_ur;
  logic [15:0]     total_ma;

  modport master (
    output ev_fatal, ev_cor, ev_ur, ev_ma, clear,
    input  tlp_err_fatal, tlp_err_cor, tlp_err_ur, tlp_master_abort,
    input  pending_any, ovf, total_fatal, total_cor, total_ur, total_ma
  );

  modport slave (
    input  ev_fatal, ev_cor, ev_ur, ev_ma, clear,
    output tlp_err_fatal, tlp_err_cor, tlp_err_ur, tlp_master_abort,
    output pending_any, ovf, total_fatal, total_cor, total_ur, total_ma
  );
endinterface

// File: rtl/pcileech_pcie_tlp_err_collector.sv
// Counts TLP error events per class and dispatches them as one-hot single-cycle pulses,
// round-robin with a minimum gap, plus saturating totals and sticky overflow flags.
module pcileech_pcie_tlp_err_collector #(
  parameter int NSRC       = 2,
  parameter int CNT_WIDTH  = 4,
  parameter int GAP_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  pcileech_pcie_tlp_err_collector_if.slave bus
);
  localparam int CW = CNT_WIDTH + 2;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [CW-1:0] MAX = CW'((1 << CNT_WIDTH) - 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_GAP  = 1'b1;

  logic [0:0]           state;
  logic [GW-1:0]        gap_cnt;
  logic [1:0]           rr_ptr;
  logic [CNT_WIDTH-1:0] pend [4];
  logic [15:0]          tot  [4];
  logic [3:0]           ovf_q;
  logic [3:0]           pulse_q;

  logic [NSRC-1:0]      ev   [4];
  logic [CW-1:0]        inc  [4];
  logic [CW-1:0]        raw  [4];
  logic [16:0]          sum  [4];
  logic [3:0]           gnt;
  logic [1:0]           gnt_idx;
  logic                 found;

  assign ev[0] = bus.ev_fatal;
  assign ev[1] = bus.ev_cor;
  assign ev[2] = bus.ev_ur;
  assign ev[3] = bus.ev_ma;

  // Grant search starts at rr_ptr so a busy class cannot starve the others.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    if (state == ST_IDLE) begin
      for (int k = 0; k < 4; k++) begin
        if (!found && pend[rr_ptr + 2'(k)] != '0) begin
          found               = 1'b1;
          gnt_idx             = rr_ptr + 2'(k);
          gnt[rr_ptr + 2'(k)] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    for (int c = 0; c < 4; c++) begin
      inc[c] = '0;
      for (int s = 0; s < NSRC; s++) begin
        inc[c] = inc[c] + CW'(ev[c][s]);
      end
      raw[c] = {2'b00, pend[c]} + inc[c] - CW'(gnt[c]);
      sum[c] = {1'b0, tot[c]} + 17'(inc[c]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst || bus.clear) begin
      state   <= ST_IDLE;
      gap_cnt <= '0;
      rr_ptr  <= '0;
      ovf_q   <= '0;
      pulse_q <= '0;
      for (int c = 0; c < 4; c++) begin
        pend[c] <= '0;
        tot[c]  <= '0;
      end
    end else begin
      pulse_q <= gnt;
      for (int c = 0; c < 4; c++) begin
        if (raw[c] > MAX) begin
          pend[c]  <= MAX[CNT_WIDTH-1:0];
          ovf_q[c] <= 1'b1;
        end else begin
          pend[c] <= raw[c][CNT_WIDTH-1:0];
        end
        tot[c] <= sum[c][16] ? 16'hFFFF : sum[c][15:0];
      end
      case (state)
        ST_IDLE: begin
          if (found) begin
            rr_ptr <= gnt_idx + 2'd1;
            if (GAP_CYCLES != 0) begin
              state   <= ST_GAP;
              gap_cnt <= GW'(GAP_CYCLES);
            end
          end
        end
        default: begin
          if (gap_cnt <= GW'(1)) state <= ST_IDLE;
          if (gap_cnt != '0) gap_cnt <= gap_cnt - GW'(1);
        end
      endcase
    end
  end

  assign bus.tlp_err_fatal    = pulse_q[0];
  assign bus.tlp_err_cor      = pulse_q[1];
  assign bus.tlp_err_ur       = pulse_q[2];
  assign bus.tlp_master_abort = pulse_q[3];
  assign bus.pending_any      = (pend[0] != '0) || (pend[1] != '0) ||
                                (pend[2] != '0) || (pend[3] != '0);
  assign bus.ovf              = ovf_q;
  assign bus.total_fatal      = tot[0];
  assign bus.total_cor        = tot[1];
  assign bus.total_ur         = tot[2];
  assign bus.total_ma         = tot[3];
endmodule
